sa_output_deskew: RTL and testbench

SA_OUTPUT_DESKEW -- requirements
Module: sa_output_deskew

---
 rtl/sa_output_deskew.sv | 125 ++++++++++++
 tb/tb_sa_output_deskew.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_output_deskew.sv
// Drains a skewed systolic-array bottom row: de-skews N columns, requantises to 8-bit pixels, queues them.
// Latency N+1 edges in->out_valid; never stalls upstream: full FIFO without a pop drops the row and sets overflow.
module sa_output_deskew #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [N*ACC_W-1:0] in_south,
  input  logic               out_ready,
  input  logic               clr_ovf,
  output logic               out_valid,
  output logic [N*8-1:0]     out_data,
  output logic               overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) << (SHIFT - 1);

  // Round half up, then clamp into 0..255 (negative results are ReLU'd to 0).
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;
    sum = $signed({acc[ACC_W-1], acc}) + RND;
    r   = sum >>> SHIFT;
    if (r[ACC_W])
      requant = 8'h00;
    else if (|r[ACC_W-1:8])
      requant = 8'hFF;
    else
      requant = r[7:0];
  endfunction

  logic [N-1:0]            vld_pipe;
  logic [N-1:0][ACC_W-1:0] aligned;
  logic [N*8-1:0]          rq_dat;
  logic                    q_vld;
  logic [N*8-1:0]          q_dat;

  logic [N*8-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic           drop;

  always_ff @(posedge clk) begin
    if (!reset_n)
      vld_pipe <= '0;
    else
      vld_pipe <= {vld_pipe[N-2:0], in_valid};
  end

  // Column c arrives c edges late, so it needs N-1-c extra stages to line up with column N-1.
  for (genvar c = 0; c < N; c++) begin : g_col
    logic [ACC_W-1:0] skew_dat [N-c];

    always_ff @(posedge clk) begin
      skew_dat[0] <= in_south[c*ACC_W +: ACC_W];
      for (int s = 1; s < N - c; s++)
        skew_dat[s] <= skew_dat[s-1];
    end

    assign aligned[c] = skew_dat[N-1-c];
  end

  always_comb begin
    rq_dat = '0;
    for (int c = 0; c < N; c++)
      rq_dat[c*8 +: 8] = requant(aligned[c]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      q_vld <= 1'b0;
    else
      q_vld <= vld_pipe[N-1];
  end

  always_ff @(posedge clk) begin
    q_dat <= rq_dat;
  end

  assign fifo_full = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same edge frees the head slot, so a full FIFO can still take the write.
  assign push      = q_vld & (~fifo_full | pop);
  assign drop      = q_vld & fifo_full & ~pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= q_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sa_output_deskew.sv
// Randomised and directed bench for sa_output_deskew, checked by a scoreboard fed from a row-level reference model.
module tb_sa_output_deskew;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int SHIFT = 8;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic [N*ACC_W-1:0] in_south;
  logic               out_ready;
  logic               clr_ovf;
  logic               out_valid;
  logic [N*8-1:0]     out_data;
  logic               overflow;

  sa_output_deskew #(.N(N), .ACC_W(ACC_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_south(in_south),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid),
    .out_data(out_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int vld_seen = 0;
  int pops_seen = 0;
  bit mon_en = 1'b0;

  // Rows most recently issued: hist[c] is the row whose column c is on the bus this edge.
  logic [N*ACC_W-1:0] hist [N];

  typedef struct {
    int             due;
    logic [N*8-1:0] px;
  } pend_t;

  pend_t          pend[$];
  logic [N*8-1:0] mq[$];
  bit             movf = 1'b0;
  int             cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_px(input longint a);
    longint d, t, q;
    d = longint'(1) << SHIFT;
    t = a + d / 2;
    q = (t >= 0) ? t / d : -((-t + d - 1) / d);
    if (q < 0) return 8'd0;
    if (q > 255) return 8'd255;
    return 8'(q);
  endfunction

  function automatic logic [N*8-1:0] ref_vec(input logic [N*ACC_W-1:0] row);
    logic [N*8-1:0] v;
    for (int c = 0; c < N; c++)
      v[c*8 +: 8] = ref_px(longint'($signed(row[c*ACC_W +: ACC_W])));
    return v;
  endfunction

  function automatic logic [N*ACC_W-1:0] rand_row();
    logic [N*ACC_W-1:0] r;
    int v;
    for (int c = 0; c < N; c++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 70000));
        1:       v = -int'($urandom_range(0, 70000));
        2:       v = int'($urandom);
        default: v = int'($urandom_range(0, 1023)) - 512;
      endcase
      r[c*ACC_W +: ACC_W] = ACC_W'(v);
    end
    return r;
  endfunction

  function automatic logic [N*ACC_W-1:0] mk_row(input int a0, input int a1, input int a2, input int a3);
    return {ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
  endfunction

  // Reference model: rows land in the FIFO N+1 edges after issue; pop first, then write or drop.
  initial begin
    bit pop_m;
    bit drop_m;
    pend_t pe;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        pend.delete();
        mq.delete();
        movf = 1'b0;
      end else begin
        pop_m  = (mq.size() > 0) && out_ready;
        drop_m = 1'b0;
        if (pop_m) void'(mq.pop_front());
        if (pend.size() > 0 && pend[0].due == cyc) begin
          if (mq.size() < DEPTH) mq.push_back(pend[0].px);
          else drop_m = 1'b1;
          void'(pend.pop_front());
        end
        if (drop_m) movf = 1'b1;
        else if (clr_ovf) movf = 1'b0;
        if (in_valid) begin
          pe.due = cyc + N + 1;
          pe.px  = ref_vec(hist[0]);
          pend.push_back(pe);
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", out_valid, mq.size() != 0);
        chk("overflow", overflow, movf);
        if (out_valid && mq.size() > 0) chk("out_data", out_data, mq[0]);
        if (out_valid) vld_seen++;
        if (out_valid && out_ready) pops_seen++;
      end
    end
  end

  task automatic step(input bit v, input logic [N*ACC_W-1:0] row, input bit rdy,
                      input bit rst_n = 1'b1, input bit clr = 1'b0);
    @(posedge clk);
    #1;
    for (int c = N - 1; c > 0; c--) hist[c] = hist[c-1];
    hist[0] = row;
    for (int c = 0; c < N; c++) in_south[c*ACC_W +: ACC_W] = hist[c][c*ACC_W +: ACC_W];
    in_valid  = v;
    out_ready = rdy;
    reset_n   = rst_n;
    clr_ovf   = clr;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, rand_row(), rdy);
  endtask

  // One isolated row with out_ready high: checks latency, pixel values and single-cycle valid.
  task automatic single(input string nm, input logic [N*ACC_W-1:0] row, input logic [N*8-1:0] expv);
    int found;
    found = -1;
    step(1'b1, row, 1'b1);
    step(1'b0, rand_row(), 1'b1);
    for (int j = 0; j < 3 * N; j++) begin
      @(negedge clk);
      if (out_valid) begin
        found = j;
        break;
      end
      step(1'b0, rand_row(), 1'b1);
    end
    chk({nm, "_latency"}, 64'(found), 64'(N + 1));
    if (found >= 0) begin
      chk({nm, "_data"}, out_data, expv);
      step(1'b0, rand_row(), 1'b1);
      @(negedge clk);
      chk({nm, "_one_cycle"}, out_valid, 1'b0);
    end
    idle(2, 1'b1);
  endtask

  initial begin
    int p0;
    int v0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    for (int c = 0; c < N; c++) hist[c] = rand_row();
    in_south  = rand_row();

    repeat (3) step(1'b1, rand_row(), 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_out_data", out_data, '0);
    mon_en = 1'b1;

    // Streaming straight out of reset with in_valid high from the first released edge.
    p0 = pops_seen;
    repeat (32) step(1'b1, rand_row(), 1'b1);
    idle(2 * N + 4, 1'b1);
    chk("stream_count", 64'(pops_seen - p0), 64'd32);

    single("example", mk_row(4736, -500, 65536, 128), {8'd1, 8'd255, 8'd0, 8'd19});
    single("rounding", mk_row(127, 128, 383, 384), {8'd2, 8'd1, 8'd1, 8'd0});

    // Six rows into a four-deep FIFO with no reader.
    repeat (6) step(1'b1, rand_row(), 1'b0);
    idle(N + 3, 1'b0);
    @(negedge clk);
    chk("bp_overflow_set", overflow, 1'b1);
    p0 = pops_seen;
    idle(8, 1'b1);
    chk("bp_drain_count", 64'(pops_seen - p0), 64'd4);
    chk("bp_overflow_held", overflow, 1'b1);
    step(1'b0, rand_row(), 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    chk("clr_ovf", overflow, 1'b0);

    // Full FIFO where the first pop coincides with the next write.
    p0 = pops_seen;
    repeat (4) step(1'b1, rand_row(), 1'b0);
    idle(N + 2, 1'b0);
    repeat (4) step(1'b1, rand_row(), 1'b0);
    idle(1, 1'b0);
    idle(12, 1'b1);
    chk("full_pop_write_count", 64'(pops_seen - p0), 64'd8);
    chk("full_pop_write_ovf", overflow, 1'b0);

    // Reset two cycles after a row while the FIFO is full and overflow is set.
    repeat (6) step(1'b1, rand_row(), 1'b0);
    idle(N + 3, 1'b0);
    step(1'b1, rand_row(), 1'b0);
    step(1'b0, rand_row(), 1'b0);
    step(1'b0, rand_row(), 1'b0, 1'b0);
    step(1'b0, rand_row(), 1'b1);
    v0 = vld_seen;
    idle(2 * N + 4, 1'b1);
    chk("midrst_no_output", 64'(vld_seen - v0), 64'd0);
    chk("midrst_overflow", overflow, 1'b0);

    repeat (600)
      step($urandom_range(0, 2) != 0, rand_row(), $urandom_range(0, 3) != 0,
           1'b1, $urandom_range(0, 15) == 0);
    idle(2 * N + DEPTH + 4, 1'b1);
    @(negedge clk);
    chk("final_empty", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
